fp_add_round_norm: RTL

//  Post-add normalize + round stage of the single-precision FP adder.
//  - Takes the raw significand sum, exponent and sign from the add/subtract stage.
//  - Normalizes: 1-bit right shift on carry-out, iterative 1-bit/cycle left shift on cancellation.
//  - Rounds round-to-nearest-even, drives Mr_round/Er_round/S/overflow to the combining stage.
//  - Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_add_round_norm.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fp_add_round_norm.sv
// Post-add normalize and round stage of the single-precision FP adder.
// Accepts the raw significand sum from the add/subtract stage, normalizes it
// (one right shift on carry-out, one left shift per cycle on cancellation),
// rounds to nearest-even and holds the result until the combining stage
// takes it. Only one operation is in flight at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for an operand, in_ready high
//   ST_NORM  | zero detect, carry right shift, or one left shift per cycle
//   ST_ROUND | round-to-nearest-even, exponent bump on carry / denormal
//   ST_DONE  | result presented, waiting for out_ready
module fp_add_round_norm #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W+3:0] in_mant,
    input  logic              in_sticky,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] Mr_round,
    output logic [EXP_W-1:0]  Er_round,
    output logic              S,
    output logic              overflow
);

    localparam int MANT_W   = FRAC_W + 4;
    localparam int CARRY_B  = MANT_W - 1;
    localparam int HIDDEN_B = MANT_W - 2;

    // Exponent math is one bit wider than the field so increments never wrap.
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = (EXP_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                sticky_q, sticky_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic                sign_q, sign_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [EXP_W-1:0]    eres_q, eres_d;
    logic                ovf_q, ovf_d;

    logic [EXP_W:0]      exp_inc;
    logic [EXP_W:0]      exp_rnd;
    logic                round_up;
    logic [FRAC_W+1:0]   rnd_sum;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mant_q   <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            frac_q   <= '0;
            eres_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            frac_q   <= frac_d;
            eres_q   <= eres_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath update: one normalize/round action per cycle.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        frac_d   = frac_q;
        eres_d   = eres_q;
        ovf_d    = ovf_q;

        exp_inc  = exp_q + EXP_ONE;
        round_up = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
        rnd_sum  = {1'b0, mant_q[HIDDEN_B:2]} + {{(FRAC_W + 1){1'b0}}, round_up};
        exp_rnd  = exp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d   = in_mant;
                    sticky_d = in_sticky;
                    exp_d    = {1'b0, in_exp};
                    sign_d   = in_sign;
                    if ({1'b0, in_exp} == EXP_MAX) begin
                        // Infinity/NaN exponent: saturate immediately.
                        frac_d  = '0;
                        eres_d  = '1;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end

            ST_NORM: begin
                if (mant_q == '0 && !sticky_q) begin
                    // Exact cancellation: signed zero, sign kept as is.
                    frac_d  = '0;
                    eres_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (mant_q[CARRY_B]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_inc;
                    if (exp_inc >= EXP_MAX) begin
                        frac_d  = '0;
                        eres_d  = '1;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ROUND;
                    end
                end else if (mant_q[HIDDEN_B]) begin
                    state_d = ST_ROUND;
                end else if (exp_q > EXP_ONE) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    // Ran out of exponent range: result stays denormal.
                    exp_d   = '0;
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                if (rnd_sum[FRAC_W + 1]) begin
                    exp_rnd = exp_inc;
                end else if (exp_q == '0 && rnd_sum[FRAC_W]) begin
                    // Denormal rounded up into the hidden bit becomes normal.
                    exp_rnd = EXP_ONE;
                end
                if (exp_rnd >= EXP_MAX) begin
                    frac_d = '0;
                    eres_d = '1;
                    ovf_d  = 1'b1;
                end else begin
                    frac_d = rnd_sum[FRAC_W-1:0];
                    eres_d = exp_rnd[EXP_W-1:0];
                    ovf_d  = 1'b0;
                end
                exp_d   = exp_rnd;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and result outputs decoded from registered state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        Mr_round  = frac_q;
        Er_round  = eres_q;
        S         = sign_q;
        overflow  = ovf_q;
    end

endmodule
